// File: rtl/debounce_array.sv
// Multi-channel run-length debouncer with one-cycle press/drop pulses.
// Optional 2-flop input synchroniser enabled by defining DEBOUNCE_ARRAY_SYNC_EN.
module debounce_array #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] on,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] drop,
    output logic             any_press
);

    localparam int CW = $clog2(DEPTH + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RISE, HELD, FALL} state_t;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] press_d;

`ifdef DEBOUNCE_ARRAY_SYNC_EN
    logic [WIDTH-1:0] sync_a;
    logic [WIDTH-1:0] sync_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= in;
            sync_b <= sync_a;
        end
    end

    assign s = sync_b;
`else
    assign s = in;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t state, state_d;
        cnt_t   cnt, cnt_d;
        logic   on_q, press_q, drop_q;
        logic   press_n, drop_n;

        // NOTE: outputs are decoded from the next state so they change on the same edge as the FSM.
        always_ff @(posedge clk) begin
            if (reset) begin
                state   <= IDLE;
                cnt     <= '0;
                on_q    <= 1'b0;
                press_q <= 1'b0;
                drop_q  <= 1'b0;
            end else begin
                state   <= state_d;
                cnt     <= cnt_d;
                on_q    <= (state_d == HELD) || (state_d == FALL);
                press_q <= press_n;
                drop_q  <= drop_n;
            end
        end

        always_comb begin
            state_d = state;
            cnt_d   = cnt;
            press_n = 1'b0;
            drop_n  = 1'b0;
            case (state)
                IDLE: begin
                    cnt_d = '0;
                    if (s[i]) begin
                        if (DEPTH == 1) begin
                            state_d = HELD;
                            press_n = 1'b1;
                        end else begin
                            state_d = RISE;
                            cnt_d   = cnt_t'(1);
                        end
                    end
                end
                RISE: begin
                    if (!s[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt == LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        press_n = 1'b1;
                    end else begin
                        cnt_d = cnt + cnt_t'(1);
                    end
                end
                HELD: begin
                    cnt_d = '0;
                    if (!s[i]) begin
                        if (DEPTH == 1) begin
                            state_d = IDLE;
                            drop_n  = 1'b1;
                        end else begin
                            state_d = FALL;
                            cnt_d   = cnt_t'(1);
                        end
                    end
                end
                FALL: begin
                    if (s[i]) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt == LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        drop_n  = 1'b1;
                    end else begin
                        cnt_d = cnt + cnt_t'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign on[i]      = on_q;
        assign press[i]   = press_q;
        assign drop[i]    = drop_q;
        assign press_d[i] = press_n;
    end

    always_ff @(posedge clk) begin
        if (reset) any_press <= 1'b0;
        else       any_press <= |press_d;
    end

endmodule
